// File: rtl/ysyx_axi4_sram_slave.sv
`timescale 1ns/1ps
// ysyx_axi4_sram_slave: AXI4 slave modelling an on-chip 64-bit SRAM.
// Latency: first read beat 1 cycle after AR (1+LAT with YSYX_AXI_SRAM_DELAY_EN); W accepted 1 cycle after AW; B 1 cycle after last W.
// Backpressure: R/B outputs held while rready/bready low; W stalled (never dropped) until AW accepted; one burst per channel at a time.
// Ports: clock/reset (sync, active-high); AR/R and AW/W/B channels of an AXI4 slave (io_slave_*).
// Optional macro YSYX_AXI_SRAM_DELAY_EN adds an R_WAIT state of LAT cycles before the first read beat.
module ysyx_axi4_sram_slave #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  MEM_BASE  = 32'h8000_0000,
  parameter int                 MEM_WORDS = 4096,
  parameter int                 LAT       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        io_slave_arburst,
  input  logic [2:0]        io_slave_arsize,
  input  logic [7:0]        io_slave_arlen,
  input  logic [3:0]        io_slave_arid,
  input  logic [ADDR_W-1:0] io_slave_araddr,
  input  logic              io_slave_arvalid,
  output logic              io_slave_arready,
  output logic [3:0]        io_slave_rid,
  output logic              io_slave_rlast,
  output logic [63:0]       io_slave_rdata,
  output logic [1:0]        io_slave_rresp,
  output logic              io_slave_rvalid,
  input  logic              io_slave_rready,
  input  logic [1:0]        io_slave_awburst,
  input  logic [2:0]        io_slave_awsize,
  input  logic [7:0]        io_slave_awlen,
  input  logic [3:0]        io_slave_awid,
  input  logic [ADDR_W-1:0] io_slave_awaddr,
  input  logic              io_slave_awvalid,
  output logic              io_slave_awready,
  input  logic              io_slave_wlast,
  input  logic [63:0]       io_slave_wdata,
  input  logic [7:0]        io_slave_wstrb,
  input  logic              io_slave_wvalid,
  output logic              io_slave_wready,
  output logic [3:0]        io_slave_bid,
  output logic [1:0]        io_slave_bresp,
  output logic              io_slave_bvalid,
  input  logic              io_slave_bready
);
  localparam int                IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(MEM_WORDS * 8);
  localparam logic [1:0]        RESP_OK   = 2'b00;
  localparam logic [1:0]        RESP_SLV  = 2'b10;

`ifdef YSYX_AXI_SRAM_DELAY_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_e;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Offset is taken modulo 2^ADDR_W, so addresses below MEM_BASE need the explicit lower-bound test.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - MEM_BASE;
    return (a >= MEM_BASE) && ({1'b0, off} < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - MEM_BASE) >> 3;
    return off[IDX_W-1:0];
  endfunction

  // WRAP is treated like INCR: the address is never folded back.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
  endfunction

  logic [63:0] mem_q [MEM_WORDS];

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, rd_addr;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
  logic [3:0]        rid_q, rid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              rd_load;
`ifdef YSYX_AXI_SRAM_DELAY_EN
  logic [3:0]        wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_load   = 1'b0;
    rd_addr   = raddr_q;
`ifdef YSYX_AXI_SRAM_DELAY_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (r_state_q)
      R_IDLE: if (io_slave_arvalid) begin
        raddr_d  = io_slave_araddr;
        rlen_d   = io_slave_arlen;
        rsize_d  = io_slave_arsize;
        rburst_d = io_slave_arburst;
        rid_d    = io_slave_arid;
        rcnt_d   = 8'd0;
`ifdef YSYX_AXI_SRAM_DELAY_EN
        r_state_d  = R_WAIT;
        wait_cnt_d = 4'(LAT - 1);
`else
        r_state_d = R_DATA;
        rd_load   = 1'b1;
        rd_addr   = io_slave_araddr;
`endif
      end
`ifdef YSYX_AXI_SRAM_DELAY_EN
      R_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          r_state_d = R_DATA;
          rd_load   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
`endif
      R_DATA: if (io_slave_rready) begin
        if (rcnt_q == rlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          rcnt_d  = rcnt_q + 8'd1;
          raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
          rd_load = 1'b1;
          rd_addr = raddr_d;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Beat data is registered when loaded, so it stays stable under stall and
    // a same-cycle write to the word is seen only by later beats.
    if (rd_load) begin
      if (in_range(rd_addr)) begin
        rdata_d = mem_q[word_idx(rd_addr)];
        rresp_d = RESP_OK;
      end else begin
        rdata_d = 64'd0;
        rresp_d = RESP_SLV;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
`ifdef YSYX_AXI_SRAM_DELAY_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef YSYX_AXI_SRAM_DELAY_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Handshake outputs are forced low while reset is held so nothing is accepted mid-reset.
  assign io_slave_arready = (r_state_q == R_IDLE) && !reset;
  assign io_slave_rvalid  = (r_state_q == R_DATA) && !reset;
  assign io_slave_rlast   = (r_state_q == R_DATA) && (rcnt_q == rlen_q) && !reset;
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rid     = rid_q;

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d, bresp_q, bresp_d;
  logic [3:0]        bid_q, bid_d;
  logic              werr_q, werr_d, beat_err, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    werr_d    = werr_q;
    beat_err  = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (io_slave_awvalid) begin
        waddr_d   = io_slave_awaddr;
        wlen_d    = io_slave_awlen;
        wsize_d   = io_slave_awsize;
        wburst_d  = io_slave_awburst;
        bid_d     = io_slave_awid;
        wcnt_d    = 8'd0;
        werr_d    = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (io_slave_wvalid) begin
        mem_we   = in_range(waddr_q) && !reset;
        // A misplaced wlast only flags the response; len still decides the beat count.
        beat_err = !in_range(waddr_q) || (io_slave_wlast != (wcnt_q == wlen_q));
        werr_d   = werr_q || beat_err;
        if (wcnt_q == wlen_q) begin
          w_state_d = W_RESP;
          bresp_d   = werr_d ? RESP_SLV : RESP_OK;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
          waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
        end
      end
      W_RESP: if (io_slave_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      bid_q     <= '0;
      bresp_q   <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      werr_q    <= werr_d;
    end
  end

  // Storage is deliberately not reset: contents survive a reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (io_slave_wstrb[i]) mem_q[word_idx(waddr_q)][8*i +: 8] <= io_slave_wdata[8*i +: 8];
      end
    end
  end

  assign io_slave_awready = (w_state_q == W_IDLE) && !reset;
  assign io_slave_wready  = (w_state_q == W_DATA) && !reset;
  assign io_slave_bvalid  = (w_state_q == W_RESP) && !reset;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;
endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
`timescale 1ns/1ps
module tb_ysyx_axi4_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;
`ifdef YSYX_AXI_SRAM_DELAY_EN
  localparam int EXP_LAT = 1 + 4;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clock = 1'b0, reset;
  logic [1:0]  arburst, awburst;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen, wstrb;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;

  ysyx_axi4_sram_slave #(.ADDR_W(32), .MEM_BASE(BASE), .MEM_WORDS(WORDS), .LAT(4)) dut (
    .clock(clock), .reset(reset),
    .io_slave_arburst(arburst), .io_slave_arsize(arsize), .io_slave_arlen(arlen),
    .io_slave_arid(arid), .io_slave_araddr(araddr), .io_slave_arvalid(arvalid),
    .io_slave_arready(arready), .io_slave_rid(rid), .io_slave_rlast(rlast),
    .io_slave_rdata(rdata), .io_slave_rresp(rresp), .io_slave_rvalid(rvalid),
    .io_slave_rready(rready), .io_slave_awburst(awburst), .io_slave_awsize(awsize),
    .io_slave_awlen(awlen), .io_slave_awid(awid), .io_slave_awaddr(awaddr),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_wlast(wlast),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wvalid(wvalid),
    .io_slave_wready(wready), .io_slave_bid(bid), .io_slave_bresp(bresp),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

  logic [63:0] mdl [WORDS];
  rexp_t rq[$];
  bexp_t bq[$];
  int n_chk = 0, n_fail = 0, r_done = 0, b_done = 0, rmode = 0;
  bit ignore_r = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    step = 32'd1 << size;
    return (burst == 2'b00) ? a : a + 32'(i) * step;
  endfunction

  function automatic bit inr(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + longint'(WORDS) * 8);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  // ready drivers: 0 = always ready, 1 = toggling rready, 2 = random
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = 1'($urandom_range(1));
      endcase
      bready = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
    end
  end

  // monitor: compares every R/B handshake against the scoreboard queues
  logic [70:0] r_hold;
  bit          r_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset || ignore_r) begin
        r_stall = 1'b0;
      end else begin
        if (r_stall) chk("r_stall_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, r_hold});
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL r_unexpected: got beat %0h expected none", rdata);
          end else begin
            chk("r_beat", {rid, rdata, rresp, rlast}, rq.pop_front());
          end
          r_done++;
        end
        r_stall = rvalid && !rready;
        r_hold  = {rid, rdata, rresp, rlast};
      end
      if (!reset && bvalid && bready) begin
        if (bq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got bresp %0h expected none", bresp);
        end else begin
          chk("b_resp", {bid, bresp}, bq.pop_front());
        end
        b_done++;
      end
    end
  end

  task automatic do_rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [3:0] id);
    int t, target;
    logic [31:0] ba;
    rexp_t e;
    target = r_done + int'(len) + 1;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, i, size, burst);
      e.id = id;
      e.last = (i == int'(len));
      if (inr(ba)) begin e.data = mdl[widx(ba)]; e.resp = 2'b00; end
      else begin e.data = 64'd0; e.resp = 2'b10; end
      rq.push_back(e);
    end
    @(posedge clock); #1;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!arready && t < 50);
    if (!arready) tmo("ar_handshake");
    @(posedge clock); #1;
    arvalid = 1'b0;
    t = 0;
    do begin @(negedge clock); t++; end while (!rvalid && t < 40);
    chk("rd_first_beat_latency", 128'(t), 128'(EXP_LAT));
    t = 0;
    while (r_done < target && t < 2000) begin @(negedge clock); t++; end
    if (r_done < target) tmo("r_burst_done");
  endtask

  // strb 0 means random strobes per beat; bad >= 0 flips wlast on that beat
  task automatic do_wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [3:0] id, input logic [63:0] d,
                       input logic [7:0] s, input bit rnd, input int bad);
    int t, target;
    bit err;
    logic [31:0] ba;
    logic [63:0] dq[$];
    logic [7:0]  sq[$];
    err = (bad >= 0);
    for (int i = 0; i <= int'(len); i++) begin
      dq.push_back(rnd ? {$urandom, $urandom} : d);
      sq.push_back((s == 8'd0) ? 8'($urandom) : s);
      ba = beat_addr(a, i, size, burst);
      if (inr(ba)) begin
        for (int b = 0; b < 8; b++) if (sq[i][b]) mdl[widx(ba)][8*b +: 8] = dq[i][8*b +: 8];
      end else err = 1'b1;
    end
    bq.push_back({id, err ? 2'b10 : 2'b00});
    target = b_done + 1;
    @(posedge clock); #1;
    awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!awready && t < 50);
    if (!awready) tmo("aw_handshake");
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (rnd && $urandom_range(1) == 1) begin @(posedge clock); #1; end
      wdata = dq[i]; wstrb = sq[i]; wlast = (i == int'(len)) ^ (i == bad); wvalid = 1'b1;
      t = 0;
      do begin @(negedge clock); t++; end while (!wready && t < 50);
      if (!wready) tmo("w_handshake");
      @(posedge clock); #1;
      wvalid = 1'b0;
    end
    t = 0;
    while (b_done < target && t < 500) begin @(negedge clock); t++; end
    if (b_done < target) tmo("b_done");
  endtask

  initial begin
    int t;
    reset = 1'b1;
    {arburst, arsize, arlen, arid, araddr, arvalid} = '0;
    {awburst, awsize, awlen, awid, awaddr, awvalid} = '0;
    {wlast, wdata, wstrb, wvalid} = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {arready, awready, wready, rvalid, bvalid, rlast, rdata, rresp, rid, bresp, bid}, 128'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11000);

    // W before AW must be held off
    @(posedge clock); #1;
    wvalid = 1'b1; wdata = 64'h1; wstrb = 8'hFF; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clock); chk("w_before_aw_stalled", wready, 1'b0); end
    @(posedge clock); #1;
    wvalid = 1'b0;

    // fill words 0..63 and the top word with known random data
    do_wr(BASE, 8'd63, 3'd3, 2'b01, 4'd1, 64'd0, 8'hFF, 1'b1, -1);
    do_wr(BASE + 32'h7FF8, 8'd0, 3'd3, 2'b01, 4'd2, 64'd0, 8'hFF, 1'b1, -1);

    do_wr(BASE, 8'd0, 3'd3, 2'b01, 4'd3, 64'h1122334455667788, 8'hFF, 1'b0, -1);
    do_rd(BASE, 8'd0, 3'd3, 2'b01, 4'd3);

    do_wr(BASE + 8, 8'd0, 3'd3, 2'b01, 4'd4, 64'd0, 8'hFF, 1'b0, -1);
    do_wr(BASE + 8, 8'd0, 3'd3, 2'b01, 4'd4, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b0, -1);
    do_rd(BASE + 8, 8'd0, 3'd3, 2'b01, 4'd4);

    rmode = 1;
    do_rd(BASE, 8'd3, 3'd3, 2'b01, 4'd5);
    rmode = 0;

    // top-of-memory crossing and a write far outside the window (aliases word 0 if unchecked)
    do_rd(BASE + 32'h7FF8, 8'd1, 3'd3, 2'b01, 4'd6);
    do_wr(32'h0, 8'd0, 3'd3, 2'b01, 4'd7, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, -1);
    do_rd(BASE, 8'd0, 3'd3, 2'b01, 4'd7);

    // early wlast: still two beats, error response
    do_wr(BASE + 16, 8'd1, 3'd3, 2'b01, 4'd8, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, 0);
    do_rd(BASE + 16, 8'd1, 3'd3, 2'b01, 4'd8);

    // read and write bursts running concurrently on disjoint words
    fork
      do_rd(BASE, 8'd7, 3'd3, 2'b01, 4'd9);
      do_wr(BASE + 8*32, 8'd7, 3'd3, 2'b01, 4'd10, 64'd0, 8'd0, 1'b1, -1);
    join
    do_rd(BASE + 8*32, 8'd7, 3'd3, 2'b01, 4'd10);

    rmode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      a     = BASE + 32'(8 * $urandom_range(55)) + 32'($urandom_range(7));
      len   = 8'($urandom_range(7));
      size  = 3'($urandom_range(3));
      burst = 2'($urandom_range(2));
      if ($urandom_range(1) == 1)
        do_wr(a, len, size, burst, 4'($urandom), 64'd0, 8'd0, 1'b1,
              ($urandom_range(7) == 0) ? int'($urandom_range(int'(len))) : -1);
      else
        do_rd(a, len, size, burst, 4'($urandom));
    end
    rmode = 0;

    // reset while the second beat of a len-7 read is presented
    ignore_r = 1'b1;
    @(posedge clock); #1;
    araddr = BASE; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arid = 4'd11; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!arready && t < 50);
    if (!arready) tmo("ar_handshake_rst");
    @(posedge clock); #1;
    arvalid = 1'b0;
    t = 0;
    do begin @(negedge clock); t++; end while (!rvalid && t < 40);
    if (!rvalid) tmo("rvalid_before_rst");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("after_reset_rvalid_arready", {rvalid, arready, awready}, 3'b011);
    ignore_r = 1'b0;
    do_rd(BASE, 8'd7, 3'd3, 2'b01, 4'd12);

    chk("scoreboard_drained", 128'(rq.size() + bq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
